// File: rtl/word_narrower_if.sv
// Handshake bundle for word_narrower: 32-bit input stream, 16-bit output
// stream and the debug compression counter.
//
// Valid/ready rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high. A source holds valid and its data
// steady until that edge. A sink may raise or lower ready freely.
interface word_narrower_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] comp_cnt;

    // Environment side: drives the producer inputs and the consumer ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  comp_cnt
    );

    // Narrower side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output comp_cnt
    );
endinterface

// File: rtl/word_narrower.sv
// word_narrower: splits 32-bit words into 16-bit halfwords, low half first.
// With COMPRESS set, a word whose upper half is zero leaves as a single beat.
// Keeps a saturating count of single-beat words for debug.
module word_narrower #(
    parameter bit COMPRESS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    word_narrower_if.slave     bus,
    output logic [1:0]         dbg_state_o
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LO    = 2'd1;
    localparam logic [1:0] S_HI    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] word_q,  word_d;
    logic [15:0] cnt_q,   cnt_d;

    logic        out_valid_w;
    logic [15:0] out_data_w;
    logic        out_last_w;
    logic        in_ready_w;
    logic        in_xfer;
    logic        out_xfer;

    // Output beat is a pure function of the state and the held word, so it
    // stays stable while the consumer stalls.
    always_comb begin
        out_valid_w = 1'b0;
        out_data_w  = 16'h0000;
        out_last_w  = 1'b0;
        case (state_q)
            S_LO: begin
                out_valid_w = 1'b1;
                out_data_w  = word_q[15:0];
                out_last_w  = COMPRESS && (word_q[31:16] == 16'h0000);
            end
            S_HI: begin
                out_valid_w = 1'b1;
                out_data_w  = word_q[31:16];
                out_last_w  = 1'b1;
            end
            default: begin
                out_valid_w = 1'b0;
                out_data_w  = 16'h0000;
                out_last_w  = 1'b0;
            end
        endcase
    end

    // Ready is taken combinationally from out_ready on the final beat so a
    // new word can follow the last beat of the previous one with no bubble.
    always_comb begin
        out_xfer   = out_valid_w & bus.out_ready;
        in_ready_w = !reset & ((state_q == S_EMPTY) | (out_xfer & out_last_w));
        in_xfer    = bus.in_valid & in_ready_w;
    end

    // Next-state, holding register and saturating counter.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        if (in_xfer) begin
            word_d = bus.in_data;
        end
        case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (out_xfer) begin
                    if (!out_last_w) begin
                        state_d = S_HI;
                    end else begin
                        state_d = in_xfer ? S_LO : S_EMPTY;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end
            S_HI: begin
                if (out_xfer) begin
                    state_d = in_xfer ? S_LO : S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // State registers; reset discards any pending halfwords at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            word_q  <= 32'h0000_0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.out_last  = out_last_w;
    assign bus.comp_cnt  = cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_word_narrower.sv
// Directed bench for word_narrower: one instance with compression enabled,
// one with it disabled, sharing clock and reset.
module tb_word_narrower;

    logic clk;
    logic reset;
    logic [1:0] dbg0, dbg1;

    int errors = 0;
    int checks = 0;

    word_narrower_if if0 ();
    word_narrower_if if1 ();

    word_narrower #(.COMPRESS(1'b1)) u_c1 (
        .clk         (clk),
        .reset       (reset),
        .bus         (if0.slave),
        .dbg_state_o (dbg0)
    );

    word_narrower #(.COMPRESS(1'b0)) u_c0 (
        .clk         (clk),
        .reset       (reset),
        .bus         (if1.slave),
        .dbg_state_o (dbg1)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let outputs settle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Check the full output beat of instance 0.
    task automatic beat0(input string tag, input logic v, input logic [15:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, if0.out_valid}, {31'd0, v});
        chk({tag, "_data"},  {16'd0, if0.out_data},  {16'd0, d});
        chk({tag, "_last"},  {31'd0, if0.out_last},  {31'd0, l});
    endtask

    task automatic beat1(input string tag, input logic v, input logic [15:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, if1.out_valid}, {31'd0, v});
        chk({tag, "_data"},  {16'd0, if1.out_data},  {16'd0, d});
        chk({tag, "_last"},  {31'd0, if1.out_last},  {31'd0, l});
    endtask

    initial begin
        reset         = 1'b1;
        if0.in_valid  = 1'b0;
        if0.in_data   = 32'h0;
        if0.out_ready = 1'b0;
        if1.in_valid  = 1'b0;
        if1.in_data   = 32'h0;
        if1.out_ready = 1'b0;

        // Reset state.
        #2;
        beat0("rst", 1'b0, 16'h0, 1'b0);
        chk("rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
        chk("rst_cnt", {16'd0, if0.comp_cnt}, 32'd0);
        chk("rst_state", {30'd0, dbg0}, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);

        // Single uncompressed word: low then high.
        if0.in_valid  = 1'b1;
        if0.in_data   = 32'h1234_ABCD;
        if0.out_ready = 1'b1;
        cyc();
        if0.in_valid = 1'b0;
        #1;
        beat0("w1_lo", 1'b1, 16'hABCD, 1'b0);
        chk("w1_lo_in_ready", {31'd0, if0.in_ready}, 32'd0);
        cyc();
        beat0("w1_hi", 1'b1, 16'h1234, 1'b1);
        chk("w1_hi_in_ready", {31'd0, if0.in_ready}, 32'd1);
        cyc();
        beat0("w1_done", 1'b0, 16'h0, 1'b0);
        chk("w1_cnt", {16'd0, if0.comp_cnt}, 32'd0);

        // Compressed stream, back to back.
        if0.in_valid = 1'b1;
        if0.in_data  = 32'h0000_0005;
        cyc();
        if0.in_data = 32'h0000_FFFF;
        #1;
        beat0("c_b0", 1'b1, 16'h0005, 1'b1);
        chk("c_b0_in_ready", {31'd0, if0.in_ready}, 32'd1);
        cyc();
        if0.in_data = 32'h0001_0000;
        #1;
        beat0("c_b1", 1'b1, 16'hFFFF, 1'b1);
        cyc();
        if0.in_valid = 1'b0;
        #1;
        beat0("c_b2", 1'b1, 16'h0000, 1'b0);
        chk("c_b2_in_ready", {31'd0, if0.in_ready}, 32'd0);
        cyc();
        beat0("c_b3", 1'b1, 16'h0001, 1'b1);
        cyc();
        beat0("c_done", 1'b0, 16'h0, 1'b0);
        chk("c_cnt", {16'd0, if0.comp_cnt}, 32'd2);

        // Compression disabled: zero word still takes two beats.
        if1.in_valid  = 1'b1;
        if1.in_data   = 32'h0000_0000;
        if1.out_ready = 1'b1;
        cyc();
        if1.in_data = 32'h0000_0007;
        #1;
        beat1("nc_b0", 1'b1, 16'h0000, 1'b0);
        chk("nc_b0_in_ready", {31'd0, if1.in_ready}, 32'd0);
        cyc();
        beat1("nc_b1", 1'b1, 16'h0000, 1'b1);
        chk("nc_b1_in_ready", {31'd0, if1.in_ready}, 32'd1);
        cyc();
        if1.in_valid = 1'b0;
        #1;
        beat1("nc_b2", 1'b1, 16'h0007, 1'b0);
        cyc();
        beat1("nc_b3", 1'b1, 16'h0000, 1'b1);
        cyc();
        beat1("nc_done", 1'b0, 16'h0, 1'b0);
        chk("nc_cnt", {16'd0, if1.comp_cnt}, 32'd0);
        if1.out_ready = 1'b0;

        // Backpressure in HI; a waiting word is ignored until ready.
        if0.in_valid = 1'b1;
        if0.in_data  = 32'hDEAD_BEEF;
        cyc();
        if0.in_valid = 1'b0;
        #1;
        beat0("bp_lo", 1'b1, 16'hBEEF, 1'b0);
        cyc();
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.in_data   = 32'h0000_0009;
        for (int i = 0; i < 5; i++) begin
            #1;
            beat0("bp_hold", 1'b1, 16'hDEAD, 1'b1);
            chk("bp_in_ready", {31'd0, if0.in_ready}, 32'd0);
            cyc();
        end
        if0.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, if0.in_ready}, 32'd1);
        beat0("bp_release", 1'b1, 16'hDEAD, 1'b1);
        cyc();
        if0.in_valid = 1'b0;
        #1;
        beat0("bp_next", 1'b1, 16'h0009, 1'b1);
        cyc();
        beat0("bp_done", 1'b0, 16'h0, 1'b0);
        chk("bp_cnt", {16'd0, if0.comp_cnt}, 32'd3);

        // Reset asserted in HI: asynchronous clear.
        if0.in_valid = 1'b1;
        if0.in_data  = 32'hCAFE_0001;
        cyc();
        if0.in_valid = 1'b0;
        cyc();
        if0.out_ready = 1'b0;
        #1;
        beat0("mr_hi", 1'b1, 16'hCAFE, 1'b1);
        reset = 1'b1;
        #1;
        beat0("mr_rst", 1'b0, 16'h0, 1'b0);
        chk("mr_rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
        chk("mr_rst_cnt", {16'd0, if0.comp_cnt}, 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mr_post_in_ready", {31'd0, if0.in_ready}, 32'd1);
        if0.in_valid  = 1'b1;
        if0.in_data   = 32'h0000_0003;
        if0.out_ready = 1'b1;
        cyc();
        if0.in_valid = 1'b0;
        #1;
        beat0("mr_w", 1'b1, 16'h0003, 1'b1);
        cyc();
        beat0("mr_done", 1'b0, 16'h0, 1'b0);
        chk("mr_cnt", {16'd0, if0.comp_cnt}, 32'd1);

        // Saturation: clear, then stream compressed words continuously.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        if0.in_valid = 1'b1;
        if0.in_data  = 32'h0000_0042;
        // First edge only accepts; each later edge sends one compressed beat.
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
        end
        #2;
        chk("sat_exact", {16'd0, if0.comp_cnt}, 32'h0000_FFFF);
        beat0("sat_beat", 1'b1, 16'h0042, 1'b1);
        cyc();
        cyc();
        chk("sat_hold", {16'd0, if0.comp_cnt}, 32'h0000_FFFF);
        if0.in_valid = 1'b0;
        cyc();
        cyc();
        beat0("sat_done", 1'b0, 16'h0, 1'b0);
        chk("sat_final", {16'd0, if0.comp_cnt}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_narrower.md
# word_narrower

Converts a stream of 32-bit words into a stream of 16-bit halfwords over valid/ready handshakes, low half first. It undoes the 16→32 zero-extension done on the immediate path: when `COMPRESS` is set and the upper half of a word is zero, it emits the word as a single halfword. The block sits between a 32-bit producer (register/ALU side) and a 16-bit consumer (immediate/instruction-field channel or narrow bus). It also keeps a saturating count of compressed words for debug.

## Interface
- `COMPRESS`, default 1: 1 lets a word with `[31:16]==0` go out as one beat; 0 always emits two beats.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_ready` output 1: block accepts the word this cycle.
- `in_data` input 32: word to narrow.
- `out_valid` output 1: halfword on `out_data` is valid.
- `out_ready` input 1: consumer takes the halfword this cycle.
- `out_data` output 16: current halfword.
- `out_last` output 1: current beat is the final beat of its word.
- `comp_cnt` output 16: number of words sent as a single beat; saturates at 0xFFFF.

## Operation
- Handshakes:
  - Input transfer when `in_valid & in_ready` on a rising edge.
  - Output transfer when `out_valid & out_ready` on a rising edge.
- Holding register `word[31:0]` captures `in_data` on every input transfer.
- FSM states:
  - `EMPTY`: `out_valid`=0, `out_data`=0, `out_last`=0.
  - `LO`: `out_valid`=1, `out_data`=`word[15:0]`, `out_last` = `COMPRESS & (word[31:16]==16'h0000)`.
  - `HI`: `out_valid`=1, `out_data`=`word[31:16]`, `out_last`=1.
- `in_ready = !reset & (state==EMPTY | (out_valid & out_ready & out_last))`.
  - This is combinational from `out_ready` to `in_ready`, which allows back-to-back words.
- Transitions:
  - `EMPTY`: input transfer → `LO`; otherwise stay.
  - `LO`, no output transfer: stay. `word` holds; `out_data` and `out_last` stay stable while `out_valid & !out_ready`.
  - `LO`, output transfer with `out_last`=0 → `HI`.
  - `LO`, output transfer with `out_last`=1: simultaneous input transfer → `LO` with the new word; otherwise → `EMPTY`.
  - `HI`, output transfer: simultaneous input transfer → `LO` with the new word; otherwise → `EMPTY`.
  - `HI`, no output transfer: stay.
- `comp_cnt` increments by 1 on each output transfer in `LO` with `out_last`=1. At 0xFFFF it holds.
- `COMPRESS`=0: every word takes exactly two beats, including `32'h0000_0000`.
- The word `32'h0000_0000` with `COMPRESS`=1 is one beat: `out_data`=0, `out_last`=1.
- The block never drops, duplicates or reorders halfwords. Ordering is always low then high.

## Timing
- Reset values (asynchronous, held while `reset`=1):
  - state `EMPTY`, `word`=0, `comp_cnt`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `in_ready`=0.
- First cycle after `reset` deasserts: `in_ready`=1.
- Latency: a word accepted at edge N has its low half valid on `out_data` in the cycle after edge N.
- Throughput with `out_ready` held high:
  - compressed words: 1 word/cycle.
  - uncompressed words: 1 word per 2 cycles.
  - `in_ready` pulses low during the `LO` beat of an uncompressed word.
- Backpressure: `out_ready`=0 stalls indefinitely with no state change.
- `in_valid` while `in_ready`=0 is ignored. The producer must hold the word until it is accepted.
- Reset asserted mid-word (in `LO` or `HI`): the pending halfwords are discarded and the block returns to `EMPTY` asynchronously. `comp_cnt` clears.

## Test plan
- Reset then single word: `in_data`=0x1234ABCD, `out_ready`=1 → beats 0xABCD (`last`=0) then 0x1234 (`last`=1); `comp_cnt`=0.
- Compression: `COMPRESS`=1, stream 0x0000_0005, 0x0000_FFFF, 0x0001_0000 with `in_valid` and `out_ready` high → beats 0x0005/L, 0xFFFF/L, 0x0000, 0x0001/L in 4 consecutive cycles; `comp_cnt`=2.
- `COMPRESS`=0: words 0x0000_0000 then 0x0000_0007 → beats 0x0000, 0x0000/L, 0x0007, 0x0000/L; `comp_cnt`=0.
- Backpressure: `out_ready`=0 for 5 cycles while in `HI` for word 0xDEAD_BEEF → `out_data`=0xDEAD stable, `out_last`=1, `in_ready`=0; the beat completes on the first cycle with `out_ready`=1.
- Reset mid-word: assert `reset` in `HI` of 0xCAFE_0001 → `out_valid`=0 immediately; after release, word 0x0000_0003 emits only 0x0003/L.
- Saturation: force 65537 compressed words → `comp_cnt` stays at 0xFFFF.
